// File: rtl/control_unit_if.sv
// Control port bundle between the hardwired control unit and the single-bus datapath.
interface control_unit_if;

    // Instruction word and halt request from the datapath side
    logic [31:0] IR;
    logic        Stop;

    // Bus drivers
    logic        PCout;
    logic        Zhighout;
    logic        Zlowout;
    logic        MDRout;
    logic        BAout;
    logic        Cout;

    // Register loads
    logic        PCin;
    logic        IRin;
    logic        MARin;
    logic        MDRin;
    logic        Yin;
    logic        Zin;
    logic        HIin;
    logic        LOin;
    logic        IncPC;

    // Register-file field selects and strobes
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;

    // Memory strobes
    logic        Read;
    logic        Write;

    // ALU operation and run status
    logic [4:0]  ALU_op;
    logic        Run;

    // Control unit side: consumes IR/Stop, drives every control line
    modport master (
        input  IR, Stop,
        output PCout, Zhighout, Zlowout, MDRout, BAout, Cout,
        output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC,
        output Gra, Grb, Grc, Rin, Rout,
        output Read, Write,
        output ALU_op, Run
    );

    // Datapath side: supplies IR/Stop, observes every control line
    modport slave (
        output IR, Stop,
        input  PCout, Zhighout, Zlowout, MDRout, BAout, Cout,
        input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC,
        input  Gra, Grb, Grc, Rin, Rout,
        input  Read, Write,
        input  ALU_op, Run
    );

endinterface

// File: rtl/control_unit.sv
// Hardwired T-state control sequencer for the single-bus datapath.
// Fetch takes T0-T2; the opcode in IR then selects the execute sequence.
// Control outputs decode combinationally from the current state and opcode.
module control_unit (
    input  logic         Clock,
    input  logic         Clear,
    control_unit_if.master bus
);

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALT
    } state_t;

    // Instruction families sharing one execute sequence
    typedef enum logic [2:0] {
        CL_NOP,
        CL_HALT,
        CL_ALU,
        CL_IMM,
        CL_MULDIV,
        CL_LD,
        CL_ST
    } class_t;

    state_t          state;
    state_t          state_nxt;
    class_t          cls;
    logic [OP_W-1:0] op;
    logic            is_last;

    logic            pc_out;
    logic            zhigh_out;
    logic            zlow_out;
    logic            mdr_out;
    logic            ba_out;
    logic            c_out;
    logic            pc_in;
    logic            ir_in;
    logic            mar_in;
    logic            mdr_in;
    logic            y_in;
    logic            z_in;
    logic            hi_in;
    logic            lo_in;
    logic            inc_pc;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            r_in;
    logic            r_out;
    logic            mem_read;
    logic            mem_write;
    logic [OP_W-1:0] alu_op;
    logic            run;

    // Register-field bits are decoded by the datapath, not here
    logic            unused_ir;

    assign op        = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    // Opcode to instruction family; anything unlisted behaves as NOP
    always_comb begin
        cls = CL_NOP;
        case (op)
            OP_LD:                     cls = CL_LD;
            OP_ST:                     cls = CL_ST;
            OP_ADD, OP_SUB, OP_SHR,
            OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR:             cls = CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:  cls = CL_IMM;
            OP_MUL, OP_DIV:            cls = CL_MULDIV;
            OP_HALT:                   cls = CL_HALT;
            default:                   cls = CL_NOP;
        endcase
    end

    // Final T-state of the current instruction; T7 always ends a sequence
    always_comb begin
        is_last = 1'b0;
        case (state)
            ST_T2:   is_last = (cls == CL_NOP);
            ST_T5:   is_last = (cls == CL_ALU) || (cls == CL_IMM);
            ST_T6:   is_last = (cls == CL_MULDIV);
            ST_T7:   is_last = 1'b1;
            default: is_last = 1'b0;
        endcase
    end

    // Next-state selection; Stop only matters on the last step
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:  state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1:   state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_T3:   state_nxt = ST_T4;
            ST_T4:   state_nxt = ST_T5;
            ST_T5:   state_nxt = ST_T6;
            ST_T6:   state_nxt = ST_T7;
            ST_T7:   state_nxt = ST_T0;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_RST;
        endcase
        if (is_last) begin
            state_nxt = bus.Stop ? ST_HALT : ST_T0;
        end
        if ((state == ST_T2) && (cls == CL_HALT)) begin
            state_nxt = ST_HALT;
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Control word for the current step
    always_comb begin
        pc_out    = 1'b0;
        zhigh_out = 1'b0;
        zlow_out  = 1'b0;
        mdr_out   = 1'b0;
        ba_out    = 1'b0;
        c_out     = 1'b0;
        pc_in     = 1'b0;
        ir_in     = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        inc_pc    = 1'b0;
        gra       = 1'b0;
        grb       = 1'b0;
        grc       = 1'b0;
        r_in      = 1'b0;
        r_out     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_op    = OP_ADD;
        run       = (state != ST_RST) && (state != ST_HALT);

        case (state)
            ST_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            ST_T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            ST_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CL_ALU, CL_IMM: begin
                        grb   = 1'b1;
                        r_out = 1'b1;
                        y_in  = 1'b1;
                    end
                    CL_MULDIV: begin
                        gra   = 1'b1;
                        r_out = 1'b1;
                        y_in  = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        grb    = 1'b1;
                        ba_out = 1'b1;
                        y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_ALU: begin
                        grc    = 1'b1;
                        r_out  = 1'b1;
                        alu_op = op;
                        z_in   = 1'b1;
                    end
                    CL_IMM: begin
                        c_out  = 1'b1;
                        alu_op = op;
                        z_in   = 1'b1;
                    end
                    CL_MULDIV: begin
                        grb    = 1'b1;
                        r_out  = 1'b1;
                        alu_op = op;
                        z_in   = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        c_out = 1'b1;
                        z_in  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CL_ALU, CL_IMM: begin
                        zlow_out = 1'b1;
                        gra      = 1'b1;
                        r_in     = 1'b1;
                    end
                    CL_MULDIV: begin
                        zlow_out = 1'b1;
                        lo_in    = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        zlow_out = 1'b1;
                        mar_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CL_MULDIV: begin
                        zhigh_out = 1'b1;
                        hi_in     = 1'b1;
                    end
                    CL_LD: begin
                        mem_read = 1'b1;
                        mdr_in   = 1'b1;
                    end
                    CL_ST: begin
                        gra    = 1'b1;
                        r_out  = 1'b1;
                        mdr_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CL_LD: begin
                        mdr_out = 1'b1;
                        gra     = 1'b1;
                        r_in    = 1'b1;
                    end
                    CL_ST: begin
                        mem_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.PCout    = pc_out;
    assign bus.Zhighout = zhigh_out;
    assign bus.Zlowout  = zlow_out;
    assign bus.MDRout   = mdr_out;
    assign bus.BAout    = ba_out;
    assign bus.Cout     = c_out;
    assign bus.PCin     = pc_in;
    assign bus.IRin     = ir_in;
    assign bus.MARin    = mar_in;
    assign bus.MDRin    = mdr_in;
    assign bus.Yin      = y_in;
    assign bus.Zin      = z_in;
    assign bus.HIin     = hi_in;
    assign bus.LOin     = lo_in;
    assign bus.IncPC    = inc_pc;
    assign bus.Gra      = gra;
    assign bus.Grb      = grb;
    assign bus.Grc      = grc;
    assign bus.Rin      = r_in;
    assign bus.Rout     = r_out;
    assign bus.Read     = mem_read;
    assign bus.Write    = mem_write;
    assign bus.ALU_op   = alu_op;
    assign bus.Run      = run;

endmodule
